lcd_text_writer: RTL
====================

// Module: lcd_text_writer
// PURPOSE
// Upstream feeder for the character-LCD controller. Accepts a stream of ASCII characters over valid/ready,
// buffers them in a small FIFO, and issues one controller transaction per character or command on
// lcd_enable/lcd_bus. Paces itself on the controller's busy flag and tracks the cursor.
// Inserts set-DDRAM-address commands when a line wraps; services clear requests.
// PARAMETERS
// FIFO_DEPTH  4      character FIFO entries, power of 2, >=2
// COLS        16     characters per display line
// LINE1_ADDR  7'h40  DDRAM base address of the second line (line 0 base is 7'h00)
// HS_TIMEOUT  8      cycles to wait for busy to rise after an lcd_enable pulse
// PORTS
// clk          in   1   single clock, all state on posedge
// rst          in   1   asynchronous, active-high reset
// char_valid   in   1   char_data valid
// char_data    in   8   ASCII character
// char_ready   out  1   FIFO not full and no clear accepted this cycle
// clear_req    in   1   single-cycle pulse: flush FIFO, clear display, home cursor
// busy         in   1   controller busy flag
// lcd_enable   out  1   one-cycle transaction strobe to controller
// lcd_bus      out  10  {rs, rw, data[7:0]} to controller; held stable until the next strobe
// cursor_col   out  clog2(COLS+1)  column of next write, 0..COLS
// cursor_line  out  1   line of next write
// err_timeout  out  1   sticky: busy never rose within HS_TIMEOUT after a strobe
// BEHAVIOUR
// - Reset values: lcd_enable=0, lcd_bus=0, char_ready=0 (until WAIT_INIT exits), cursor_col=0,
//   cursor_line=0, err_timeout=0, FIFO empty, clear_pending=0, state=WAIT_INIT.
// - FIFO push when char_valid&&char_ready. Pop only in IDLE, when issuing a character.
//   Full: char_ready=0. Push and pop in the same cycle are allowed and keep the count unchanged.
// - clear_req: flushes the FIFO and sets clear_pending in the same cycle. char_ready=0 that cycle.
//   A simultaneous char_valid is dropped. clear_req during an in-flight transaction does not abort it.
// - FSM:
//   WAIT_INIT: wait for busy=1, then busy=0, then go to IDLE. This covers the controller power-up/init sequence.
//   IDLE: highest priority is clear_pending -> issue {2'b00,8'h01}; set col=0, line=0; clear clear_pending.
//     Else if FIFO not empty and col==COLS -> issue {2'b00,1'b1,addr}, where addr=LINE1_ADDR when
//     line was 0 and 7'h00 when line was 1. Toggle line, col=0, no pop.
//     Else if FIFO not empty -> issue {2'b10,char}; pop; col=col+1.
//     Issuing any transaction means: lcd_enable=1 for exactly one cycle, and the lcd_bus update is registered
//     in the same cycle. Then go to WAIT_HI.
//   WAIT_HI: lcd_enable=0. busy=1 -> WAIT_LO. After HS_TIMEOUT cycles without busy -> set err_timeout, go to IDLE.
//   WAIT_LO: busy=0 -> IDLE. lcd_enable may next assert no earlier than the cycle after busy is seen low.
// - lcd_enable is never asserted while busy=1 or outside IDLE. At most one strobe per transaction.
// - Wrap is lazy: after the COLS-th character col stays at COLS. The address command is issued
//   only when another character is pending. Line 1 wraps to line 0.
// - Cursor updates take effect at the strobe cycle, not at completion.
// - Async rst mid-transaction: all outputs return to reset values immediately and the FSM returns to WAIT_INIT.
//   The bench must then drive busy high-then-low before traffic resumes.
// TESTING
// - Init: hold busy=1 for 20 cycles then 0 -> no lcd_enable during WAIT_INIT; char_ready rises after busy falls.
// - Push 'A'(8'h41) -> one lcd_enable pulse with lcd_bus=10'h241; no second strobe until busy has gone 1 then 0; col=1.
// - Push 17 chars with a busy model of 51 cycles -> after 16 data writes, lcd_bus=10'h0C0 (address 0x40) precedes the 17th; line=1, col=1.
// - Fill FIFO (4 pushes while busy) -> char_ready=0; pop on next IDLE restores char_ready the following cycle.
// - clear_req together with char_valid while 3 chars are queued -> FIFO empty, char dropped; next strobe carries 10'h001; col=0, line=0.
// - Strobe with busy tied 0 -> err_timeout=1 after 8 cycles; FSM returns to IDLE and the next char is still issued.

Source files
------------

// File: rtl/lcd_text_writer.sv
// Character feeder for the character-LCD controller: buffers ASCII input, issues one controller
// transaction per character or command, tracks the cursor and inserts line-wrap address commands.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_INIT_HI  | controller power-up: waiting for busy to rise
// S_INIT_LO  | controller power-up: waiting for busy to fall
// S_IDLE     | may strobe a clear, wrap-address or character transaction
// S_WAIT_HI  | strobe sent, waiting (bounded) for busy to rise
// S_WAIT_LO  | controller working, waiting for busy to fall
module lcd_text_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COLS       = 16,
    parameter logic [6:0]  LINE1_ADDR = 7'h40,
    parameter int unsigned HS_TIMEOUT = 8,
    localparam int unsigned COL_W     = $clog2(COLS + 1),
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1),
    localparam int unsigned TMR_W     = $clog2(HS_TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             char_ready,
    input  logic             clear_req,
    input  logic             busy,
    output logic             lcd_enable,
    output logic [9:0]       lcd_bus,
    output logic [COL_W-1:0] cursor_col,
    output logic             cursor_line,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        S_INIT_HI,
        S_INIT_LO,
        S_IDLE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t             state, state_nx;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full, fifo_empty;
    logic               push, pop;
    logic               clear_pending, clr_done;
    logic [TMR_W-1:0]   tmr, tmr_nx;
    logic               err_set;
    logic               issue;
    logic [9:0]         issue_word, bus_q;
    logic [COL_W-1:0]   col_nx;
    logic               line_nx;

    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign char_ready = (state != S_INIT_HI) && (state != S_INIT_LO) && !fifo_full && !clear_req;
    assign push       = char_valid && char_ready;

    // The strobe and the word it carries are presented together; bus_q holds the word afterwards.
    assign lcd_enable = issue;
    assign lcd_bus    = issue ? issue_word : bus_q;

    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        issue_word = '0;
        pop        = 1'b0;
        clr_done   = 1'b0;
        col_nx     = cursor_col;
        line_nx    = cursor_line;
        tmr_nx     = tmr;
        err_set    = 1'b0;
        case (state)
            S_INIT_HI: begin
                if (busy) state_nx = S_INIT_LO;
            end
            S_INIT_LO: begin
                if (!busy) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (!busy) begin
                    if (clear_pending) begin
                        issue      = 1'b1;
                        issue_word = {2'b00, 8'h01};
                        col_nx     = '0;
                        line_nx    = 1'b0;
                        clr_done   = 1'b1;
                    end else if (!fifo_empty && cursor_col == COL_W'(COLS)) begin
                        // Lazy wrap: address command only once another character is waiting.
                        issue      = 1'b1;
                        issue_word = {3'b001, (cursor_line ? 7'h00 : LINE1_ADDR)};
                        col_nx     = '0;
                        line_nx    = !cursor_line;
                    end else if (!fifo_empty) begin
                        issue      = 1'b1;
                        issue_word = {2'b10, fifo_mem[rd_ptr]};
                        pop        = 1'b1;
                        col_nx     = cursor_col + COL_W'(1);
                    end
                end
                if (issue) begin
                    state_nx = S_WAIT_HI;
                    tmr_nx   = TMR_W'(HS_TIMEOUT - 1);
                end
            end
            S_WAIT_HI: begin
                if (busy) begin
                    state_nx = S_WAIT_LO;
                end else if (tmr == '0) begin
                    err_set  = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!busy) state_nx = S_IDLE;
            end
            default: state_nx = S_INIT_HI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_INIT_HI;
            tmr           <= '0;
            bus_q         <= '0;
            cursor_col    <= '0;
            cursor_line   <= 1'b0;
            err_timeout   <= 1'b0;
            clear_pending <= 1'b0;
        end else begin
            state       <= state_nx;
            tmr         <= tmr_nx;
            cursor_col  <= col_nx;
            cursor_line <= line_nx;
            if (issue)   bus_q       <= issue_word;
            if (err_set) err_timeout <= 1'b1;
            // A new clear request wins over retiring the one being issued this cycle.
            if (clear_req)     clear_pending <= 1'b1;
            else if (clr_done) clear_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (clear_req) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= char_data;
    end

endmodule
